// File: rtl/imm_ext_pkg.sv
// Shared definitions for the decode-side immediate extender: tipo encodings,
// the default-width payload, and the pure extension/shift functions.
package imm_ext_pkg;

    localparam int IMM_MAX   = 64;  // widest XLEN the helper functions support
    localparam int IMM_XLEN  = 32;
    localparam int IMM_TAG_W = 5;

    typedef enum logic [1:0] {
        IMM_T17 = 2'b00,
        IMM_T20 = 2'b01,
        IMM_T24 = 2'b10,
        IMM_T28 = 2'b11
    } imm_tipo_e;

    typedef struct packed {
        logic [IMM_XLEN-1:0]  salida;
        logic [IMM_TAG_W-1:0] tag;
        logic                 trunc;
    } imm_payload_t;

    // Keeps entrada[w-1:0] and fills everything above with the field MSB or zero.
    function automatic logic [IMM_MAX-1:0] imm_sext(input logic [IMM_MAX-1:0] entrada,
                                                    input int w, input logic zext);
        logic               sign;
        logic [IMM_MAX-1:0] ext;
        sign = 1'b0;
        for (int i = 0; i < IMM_MAX; i++) begin
            if (i == w - 1) sign = entrada[i];
        end
        for (int i = 0; i < IMM_MAX; i++) begin
            ext[i] = (i < w) ? entrada[i] : (sign & ~zext);
        end
        return ext;
    endfunction

    // Callers truncate the result to their own XLEN; the low XLEN bits are exact.
    function automatic logic [IMM_MAX-1:0] imm_extend(input logic [IMM_MAX-1:0] entrada,
                                                      input int w, input logic zext,
                                                      input logic shl2);
        logic [IMM_MAX-1:0] ext;
        ext = imm_sext(entrada, w, zext);
        return shl2 ? (ext << 2) : ext;
    endfunction

    // Flags a left-by-2 that loses significant bits at the given XLEN.
    function automatic logic imm_trunc(input logic [IMM_MAX-1:0] entrada, input int w,
                                       input int xlen, input logic zext, input logic shl2);
        logic [IMM_MAX-1:0] ext;
        logic               b1, b2, b3;
        ext = imm_sext(entrada, w, zext);
        b1  = 1'b0;
        b2  = 1'b0;
        b3  = 1'b0;
        for (int i = 0; i < IMM_MAX; i++) begin
            if (i == xlen - 1) b1 = ext[i];
            if (i == xlen - 2) b2 = ext[i];
            if (i == xlen - 3) b3 = ext[i];
        end
        if (!shl2)      return 1'b0;
        else if (zext)  return b1 | b2;
        else            return !((b1 == b2) && (b2 == b3));
    endfunction

endpackage

// File: rtl/imm_ext_skid.sv
// Generic two-entry valid/ready buffer: output register plus one skid entry.
// in_ready is registered so it never depends combinationally on out_ready.
module imm_ext_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] skid_data;
    logic         in_xfer;
    logic         out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // The skid entry is occupied exactly when in_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: payload flops are reset as well because the output data must read 0 in reset.
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
            in_ready  <= 1'b1;
        end else if (out_xfer) begin
            // NOTE: non-blocking everywhere here so every flop samples pre-edge values.
            if (!in_ready) begin
                out_data <= skid_data;
                in_ready <= 1'b1;
            end else if (in_xfer) begin
                out_data <= in_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            if (out_valid) begin
                skid_data <= in_data;
                in_ready  <= 1'b0;
            end else begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender between decode and execute with valid/ready and a tag.
// Define IMM_EXT_SKID_EN for a 2-deep buffer with a registered in_ready.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IN_W  = 28,
    parameter int W0    = 17,
    parameter int W1    = 20,
    parameter int W2    = 24,
    parameter int W3    = 28,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_entrada,
    input  logic [1:0]       in_tipo,
    input  logic             in_zext,
    input  logic             in_shl2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_salida,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_trunc
);

    typedef struct packed {
        logic [XLEN-1:0]  salida;
        logic [TAG_W-1:0] tag;
        logic             trunc;
    } payload_t;

    payload_t cand;
    payload_t out_q;

    // One constant-width extender per tipo, then a 4:1 select.
    always_comb begin
        // NOTE: default the whole struct first so no path leaves a field unassigned (latch).
        cand     = '0;
        cand.tag = in_tag;
        case (imm_tipo_e'(in_tipo))
            IMM_T17: begin
                cand.salida = XLEN'(imm_extend(IMM_MAX'(in_entrada), W0, in_zext, in_shl2));
                cand.trunc  = imm_trunc(IMM_MAX'(in_entrada), W0, XLEN, in_zext, in_shl2);
            end
            IMM_T20: begin
                cand.salida = XLEN'(imm_extend(IMM_MAX'(in_entrada), W1, in_zext, in_shl2));
                cand.trunc  = imm_trunc(IMM_MAX'(in_entrada), W1, XLEN, in_zext, in_shl2);
            end
            IMM_T24: begin
                cand.salida = XLEN'(imm_extend(IMM_MAX'(in_entrada), W2, in_zext, in_shl2));
                cand.trunc  = imm_trunc(IMM_MAX'(in_entrada), W2, XLEN, in_zext, in_shl2);
            end
            IMM_T28: begin
                cand.salida = XLEN'(imm_extend(IMM_MAX'(in_entrada), W3, in_zext, in_shl2));
                cand.trunc  = imm_trunc(IMM_MAX'(in_entrada), W3, XLEN, in_zext, in_shl2);
            end
        endcase
    end

`ifdef IMM_EXT_SKID_EN
    imm_ext_skid #(
        .W($bits(payload_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (cand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_q)
    );
`else
    logic out_valid_q;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (in_valid && in_ready) begin
            out_valid_q <= 1'b1;
            out_q       <= cand;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_salida = out_q.salida;
    assign out_tag    = out_q.tag;
    assign out_trunc  = out_q.trunc;

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Registered, parametrised immediate extender between decode and execute. It selects one of four immediate fields by `in_tipo`, then sign- or zero-extends it to `XLEN`. It can optionally scale the result by 4 for branch and jump offsets. A valid/ready handshake carries a pass-through tag, so decode and execute can stall independently.

## Interface
- `XLEN`, 32: output datapath width.
- `IN_W`, 28: raw immediate input width. Must be ≤ `XLEN`.
- `W0`, 17: field width for `tipo`=00.
- `W1`, 20: field width for `tipo`=01.
- `W2`, 24: field width for `tipo`=10.
- `W3`, 28: field width for `tipo`=11.
- Each `Wk` is in 1..`IN_W`.
- `TAG_W`, 5: width of the pass-through tag (destination register id).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input item present.
- `in_ready` out 1: block accepts the item this cycle.
- `in_entrada` in `IN_W`: raw immediate. Bits at and above the selected `Wk` are ignored.
- `in_tipo` in 2: field-width select.
- `in_zext` in 1: 1 = zero-extend, 0 = sign-extend.
- `in_shl2` in 1: 1 = shift the extended value left by 2.
- `in_tag` in `TAG_W`: carried unchanged to the output.
- `out_valid` out 1: output item present.
- `out_ready` in 1: consumer takes the item this cycle.
- `out_salida` out `XLEN`: extended, optionally shifted, immediate.
- `out_tag` out `TAG_W`: tag of the item.
- `out_trunc` out 1: the shift discarded significant bits.

## Operation
- An input transfer occurs when `in_valid` & `in_ready`. An output transfer occurs when `out_valid` & `out_ready`.
- Extension: take `in_entrada[Wk-1:0]`.
  - Upper `XLEN-Wk` bits = `in_entrada[Wk-1]` if `in_zext`=0, else 0.
- Shift: if `in_shl2`=1, result = extended value << 2; bits shifted out are lost and the low 2 bits are 0.
- `out_trunc`, when `in_shl2`=1:
  - Sign mode: extended bits [XLEN-1:XLEN-3] are not all equal.
  - Zero mode: extended bits [XLEN-1:XLEN-2] are nonzero.
  - When `in_shl2`=0, `out_trunc` = 0.
- Computation is done before the output register; the output register holds final values only.
- Items leave strictly in acceptance order. No item is dropped or duplicated.
- While `out_valid`=1 and `out_ready`=0, `out_salida`, `out_tag` and `out_trunc` hold stable.
- The block accepts all four `tipo` encodings; there is no illegal encoding.

## Timing
- Latency: an item accepted at edge N is presented with `out_valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 item/cycle when `out_ready`=1 continuously.
- Reset, asynchronous on `rst_n` low:
  - `out_valid`=0, `out_salida`=0, `out_tag`=0, `out_trunc`=0; all held items are discarded.
  - `in_ready`=1 while in reset and after release.
- Simultaneous input and output transfer in the same cycle: the new item replaces or queues behind the departing item. Occupancy is unchanged.
- Full: `in_ready`=0. `in_entrada` is ignored regardless of `in_valid`.
- Empty: `out_valid`=0. `out_ready` is ignored.
- Reset asserted mid-transfer overrides any handshake in that cycle.

## Configuration
- `IMM_EXT_SKID_EN` defined:
  - Capacity 2: output register plus one skid entry.
  - `in_ready` is a flop equal to "skid entry empty", with no combinational path from `out_ready`.
  - When the skid entry is occupied and an output transfer occurs, the skid item moves to the output register. `in_ready` returns to 1 on the following edge.
- Not defined:
  - Capacity 1.
  - `in_ready` = !`out_valid` | `out_ready`, combinational.

## Structure
- Package `imm_ext_pkg`:
  - Tipo encodings `IMM_T17`=2'b00, `IMM_T20`=2'b01, `IMM_T24`=2'b10, `IMM_T28`=2'b11.
  - The payload struct {salida, tag, trunc}.
  - The pure extension/shift function, shared with the decoder.
- Sub-module `imm_ext_skid`: a generic 2-entry payload buffer, instantiated only under `IMM_EXT_SKID_EN`.

## Test plan
- `tipo`=00, `entrada`=28'h0010000, `zext`=0, `shl2`=0 → `out_salida`=32'hFFFF0000 one cycle later; `out_trunc`=0.
- `tipo`=11, `entrada`=28'h8000001 → `out_salida`=32'hF8000001 with `zext`=0, and 32'h08000001 with `zext`=1.
- `tipo`=00, `entrada`=28'hFFE0001 → 32'h00000001, confirming upper bits are ignored.
- `tipo`=01, `entrada`=28'h00FFFFF, `shl2`=1 → 32'hFFFFFFFC, `trunc`=0.
- Parametrised XLEN=16, IN_W=16, W3=16 with `tipo`=11, `entrada`=16'h4000, `shl2`=1, `zext`=0 → 16'h0000, `trunc`=1.
- Backpressure: `out_ready`=0, three items with tags 1, 2, 3 offered back-to-back.
  - `in_ready` falls after 1 item (macro off) or 2 items (macro on).
  - Release `out_ready` → tags emerge 1, 2, 3 in order.
  - `rst_n` pulsed low while full → `out_valid`=0 immediately and `in_ready`=1.
